wbm_initiator: RTL

WBM_INITIATOR -- requirements
Module: wbm_initiator

---
 rtl/wbm_initiator.sv | 112 +++++++++++
 1 files changed

// File: rtl/wbm_initiator.sv
// Single-outstanding Wishbone classic-cycle initiator: turns one request into one
// bus cycle and returns ack / bus-error / timeout as a response.
module wbm_initiator #(
   parameter int unsigned TIMEOUT = 10
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_n_i,

   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [3:0]  req_sel_i,
   input  logic [31:0] req_adr_i,
   input  logic [31:0] req_dat_i,

   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_dat_o,
   output logic [1:0]  rsp_status_o,

   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   input  logic        wbm_err_i,

   output logic [15:0] err_cnt_o
);

   typedef enum logic [1:0] {
      IDLE,
      BUS,
      RESP
   } state_t;

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   state_t      state;
   logic [15:0] tmo_cnt;

   assign wbm_stb_o = wbm_cyc_o;

   // req_ready_o comes up one edge after reset release, so the first accept needs
   // both the registered ready and a valid request.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state        <= IDLE;
         req_ready_o  <= 1'b0;
         rsp_valid_o  <= 1'b0;
         rsp_dat_o    <= 32'h0;
         rsp_status_o <= 2'b00;
         wbm_cyc_o    <= 1'b0;
         wbm_we_o     <= 1'b0;
         wbm_sel_o    <= 4'h0;
         wbm_adr_o    <= 32'h0;
         wbm_dat_o    <= 32'h0;
         err_cnt_o    <= 16'h0;
         tmo_cnt      <= 16'h0;
      end else begin
         case (state)
            IDLE: begin
               req_ready_o <= 1'b1;
               if (req_ready_o && req_valid_i) begin
                  req_ready_o <= 1'b0;
                  wbm_cyc_o   <= 1'b1;
                  wbm_we_o    <= req_we_i;
                  wbm_sel_o   <= req_sel_i;
                  wbm_adr_o   <= req_adr_i;
                  wbm_dat_o   <= req_dat_i;
                  tmo_cnt     <= 16'h0;
                  state       <= BUS;
               end
            end
            BUS: begin
               if (wbm_ack_i) begin
                  wbm_cyc_o    <= 1'b0;
                  rsp_valid_o  <= 1'b1;
                  rsp_status_o <= 2'b00;
                  rsp_dat_o    <= wbm_we_o ? 32'h0 : wbm_dat_i;
                  state        <= RESP;
               end else if (wbm_err_i || tmo_cnt == TMO_LAST) begin
                  wbm_cyc_o    <= 1'b0;
                  rsp_valid_o  <= 1'b1;
                  rsp_status_o <= wbm_err_i ? 2'b01 : 2'b10;
                  rsp_dat_o    <= 32'h0;
                  if (err_cnt_o != 16'hFFFF) begin
                     err_cnt_o <= err_cnt_o + 16'h1;
                  end
                  state        <= RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + 16'h1;
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_o <= 1'b0;
                  req_ready_o <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
